// File: rtl/fir_mac_engine_pkg.sv
// fir_pkg: shared constants, FSM state type and output-scaling helpers for
// the 64-tap FIR multiply-accumulate engine.
// Optional feature macro: FIR_MAC_SAT_EN (narrow() saturates instead of wraps).
package fir_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 64;
    localparam int TAP_WIDTH  = $clog2(DEPTH);
    localparam int ACC_WIDTH  = 2*DATA_WIDTH + TAP_WIDTH;
    localparam int SHIFT      = 15;
    localparam int OUT_WIDTH  = 16;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} mac_state_t;

    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(2**(SHIFT-1));
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX    = ACC_WIDTH'(2**(OUT_WIDTH-1)-1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN    = ~OUT_MAX;

    // Round half up, then arithmetic shift down to the output scale.
    function automatic logic signed [ACC_WIDTH-1:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] acc
    );
        logic signed [ACC_WIDTH-1:0] biased;
        biased = acc + ROUND_BIAS;
        return biased >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] narrow(
        input logic signed [ACC_WIDTH-1:0] v
    );
`ifdef FIR_MAC_SAT_EN
        if (v > OUT_MAX)
            return OUT_WIDTH'(OUT_MAX);
        else if (v < OUT_MIN)
            return OUT_WIDTH'(OUT_MIN);
        else
            return OUT_WIDTH'(v);
`else
        return OUT_WIDTH'(v);
`endif
    endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// fir_mac_engine_if: groups the sample stream, coefficient-memory bus and
// status outputs of fir_mac_engine.
//   slave  : engine side (consumes din/coef, produces din_ready/rd_en/dout/status)
//   master : environment side (sample source, coefficient memory, sink)
interface fir_mac_engine_if;
    import fir_pkg::*;

    logic signed [DATA_WIDTH-1:0] din;
    logic                         din_valid;
    logic                         din_ready;
    logic                         rd_en;
    logic signed [DATA_WIDTH-1:0] coef_in;
    logic                         coef_done;
    logic signed [OUT_WIDTH-1:0]  dout;
    logic                         dout_valid;
    logic                         busy;
    logic                         coef_sync_err;

    modport slave (
        input  din, din_valid, coef_in, coef_done,
        output din_ready, rd_en, dout, dout_valid, busy, coef_sync_err
    );

    modport master (
        output din, din_valid, coef_in, coef_done,
        input  din_ready, rd_en, dout, dout_valid, busy, coef_sync_err
    );
endinterface

// File: rtl/fir_mac_engine_sample_hist.sv
// fir_sample_hist: DEPTH-entry circular sample history.
// Ports:
//   clk, rstn   clock, async active-low reset (clears all entries)
//   wr_en       write wr_data into entry wr_addr
//   wr_addr     write address
//   wr_data     sample to store
//   rd_addr     tap read address
//   rd_data     registered read of entry rd_addr (one cycle latency)
module fir_sample_hist
    import fir_pkg::*;
(
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_en,
    input  logic [TAP_WIDTH-1:0]         wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic [TAP_WIDTH-1:0]         rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: per accepted sample, streams DEPTH coefficients out of the
// coefficient memory, multiply-accumulates them against the sample history
// and emits one rounded, narrowed output.
// Optional feature macro: FIR_MAC_SAT_EN (saturate output instead of wrap).
// Ports:
//   clk    clock
//   rstn   async active-low reset
//   mac    fir_mac_engine_if.slave: din/din_valid/din_ready, rd_en,
//          coef_in/coef_done, dout/dout_valid, busy, coef_sync_err
//
// state | meaning
// IDLE  | waiting for a sample, din_ready high
// FETCH | rd_en high for DEPTH cycles, taps 0..DEPTH-1 addressed
// DRAIN | last coefficient arrives, final accumulate, dout loaded
// OUT   | dout_valid pulse, write pointer advances
module fir_mac_engine
    import fir_pkg::*;
(
    input logic              clk,
    input logic              rstn,
    fir_mac_engine_if.slave  mac
);

    localparam logic [TAP_WIDTH-1:0] TAP_LAST = TAP_WIDTH'(DEPTH-1);

    mac_state_t                    state, state_nxt;
    logic [TAP_WIDTH-1:0]          wp;
    logic [TAP_WIDTH-1:0]          tap;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [DATA_WIDTH-1:0]  x_tap;
    logic signed [OUT_WIDTH-1:0]   dout_r;
    logic                          mac_en;
    logic                          last_tap;
    logic                          sync_err;
    logic                          accept;
    logic                          din_ready_c, rd_en_c, dout_valid_c, busy_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        din_ready_c  = 1'b0;
        rd_en_c      = 1'b0;
        dout_valid_c = 1'b0;
        busy_c       = 1'b1;
        case (state)
            IDLE: begin
                din_ready_c = 1'b1;
                busy_c      = 1'b0;
                if (mac.din_valid)
                    state_nxt = FETCH;
            end
            FETCH: begin
                rd_en_c = 1'b1;
                if (tap == TAP_LAST)
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = OUT;
            OUT: begin
                dout_valid_c = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && mac.din_valid;

    fir_sample_hist u_hist (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (accept),
        .wr_addr (wp),
        .wr_data (mac.din),
        .rd_addr (wp - tap),
        .rd_data (x_tap)
    );

    assign product = mac.coef_in * x_tap;
    assign acc_sum = acc + ACC_WIDTH'(product);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp       <= '0;
            tap      <= '0;
            acc      <= '0;
            mac_en   <= 1'b0;
            last_tap <= 1'b0;
            dout_r   <= '0;
            sync_err <= 1'b0;
        end else begin
            // Coefficient data lags rd_en by one cycle; mac_en/last_tap
            // track which cycle carries c[i] and whether it is c[DEPTH-1].
            mac_en   <= rd_en_c;
            last_tap <= (state == FETCH) && (tap == TAP_LAST);

            if (accept)
                tap <= '0;
            else if (state == FETCH)
                tap <= tap + TAP_WIDTH'(1);

            if (state == OUT)
                wp <= wp + TAP_WIDTH'(1);

            if (accept)
                acc <= '0;
            else if (mac_en)
                acc <= acc_sum;

            // DRAIN carries the final product, so dout uses the combined sum.
            if (state == DRAIN)
                dout_r <= narrow(round_shift(acc_sum));

            if (mac_en && (mac.coef_done != last_tap))
                sync_err <= 1'b1;
        end
    end

    assign mac.din_ready     = din_ready_c;
    assign mac.rd_en         = rd_en_c;
    assign mac.dout_valid    = dout_valid_c;
    assign mac.busy          = busy_c;
    assign mac.dout          = dout_r;
    assign mac.coef_sync_err = sync_err;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed test of fir_mac_engine with a behavioural
// coefficient memory (registered read, readco_done on the last word).
module tb_fir_mac_engine;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   fault_tap = -1;

    logic signed [15:0] coefs [64];
    logic [5:0]         mem_cnt;

    fir_mac_engine_if if0();

    fir_mac_engine dut (
        .clk  (clk),
        .rstn (rstn),
        .mac  (if0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Coefficient memory model sharing rstn.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_cnt      <= '0;
            if0.coef_in   <= '0;
            if0.coef_done <= 1'b0;
        end else begin
            if0.coef_done <= 1'b0;
            if (if0.rd_en) begin
                if0.coef_in   <= coefs[mem_cnt];
                if0.coef_done <= (mem_cnt == 6'd63) || (int'(mem_cnt) == fault_tap);
                mem_cnt      <= mem_cnt + 6'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_coefs(input logic signed [15:0] c0, input logic signed [15:0] rest);
        coefs[0] = c0;
        for (int i = 1; i < 64; i++) coefs[i] = rest;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!if0.din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if0.din_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_dout(output logic [15:0] y);
        int n;
        n = 0;
        @(negedge clk);
        while (!if0.dout_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!if0.dout_valid) check("dout_timeout", 0, 1);
        y = if0.dout;
    endtask

    task automatic send_sample(input logic [15:0] x, output logic [15:0] y);
        wait_ready();
        if0.din       = x;
        if0.din_valid = 1'b1;
        @(posedge clk);
        #1 if0.din_valid = 1'b0;
        wait_dout(y);
    endtask

    logic [15:0]  y;
    logic [127:0] rd_pat, dv_pat, dr_pat, rd_exp, dv_exp, dr_exp;
    logic [15:0]  dout_t66;
    int           t_acc [4];

    initial begin
        if0.din       = '0;
        if0.din_valid = 1'b0;
        set_coefs(16'sh4000, 16'sh4000);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_din_ready", if0.din_ready, 1);
        check("rst_rd_en", if0.rd_en, 0);
        check("rst_dout_valid", if0.dout_valid, 0);
        check("rst_busy", if0.busy, 0);
        check("rst_dout", 128'($unsigned(if0.dout)), 0);
        check("rst_sync_err", if0.coef_sync_err, 0);
        rstn = 1'b1;

        // Timing of one sample period; doubles as the first impulse sample.
        rd_pat = '0; dv_pat = '0; dr_pat = '0;
        rd_exp = '0; dv_exp = '0; dr_exp = '0;
        dout_t66 = '0;
        for (int k = 1; k <= 70; k++) begin
            rd_exp[k] = (k <= 64);
            dv_exp[k] = (k == 66);
            dr_exp[k] = (k >= 67);
        end
        wait_ready();
        if0.din       = 16'h7FFF;
        if0.din_valid = 1'b1;
        @(posedge clk);
        #1 if0.din_valid = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            rd_pat[k] = if0.rd_en;
            dv_pat[k] = if0.dout_valid;
            dr_pat[k] = if0.din_ready;
            if (k == 66) dout_t66 = if0.dout;
        end
        check("timing_rd_en", rd_pat, rd_exp);
        check("timing_dout_valid", dv_pat, dv_exp);
        check("timing_din_ready", dr_pat, dr_exp);
        check("impulse_0", dout_t66, 16'h4000);

        // Rest of impulse response, including write-pointer wrap.
        for (int i = 1; i <= 65; i++) begin
            send_sample(16'h0000, y);
            check($sformatf("impulse_%0d", i), y, (i <= 63) ? 16'h4000 : 16'h0000);
        end
        check("impulse_sync_err", if0.coef_sync_err, 0);

        // Step into overflow.
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            send_sample(16'h4000, y);
`ifdef FIR_MAC_SAT_EN
            check($sformatf("step_%0d", n), y, (n <= 3) ? 16'(n * 16'h2000) : 16'h7FFF);
`else
            check($sformatf("step_%0d", n), y, 16'(n * 16'h2000));
`endif
        end

        // Backpressure: din_valid held high, ramp input, pass-through c[0].
        do_reset();
        set_coefs(16'sh7FFF, 16'sh0000);
        if0.din       = 16'd1;
        if0.din_valid = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            wait_ready();
            @(posedge clk);
            t_acc[s-1] = cyc;
            #1 if0.din = 16'(s + 1);
            wait_dout(y);
            check($sformatf("ramp_%0d", s), y, 16'(s));
        end
        if0.din_valid = 1'b0;
        for (int s = 1; s <= 3; s++)
            check($sformatf("ramp_period_%0d", s), t_acc[s] - t_acc[s-1], 67);

        // Reset during FETCH at tap 20.
        do_reset();
        set_coefs(16'sh4000, 16'sh4000);
        wait_ready();
        if0.din       = 16'h1234;
        if0.din_valid = 1'b1;
        @(posedge clk);
        #1 if0.din_valid = 1'b0;
        repeat (21) @(negedge clk);
        check("midrst_pre_rd_en", if0.rd_en, 1);
        rstn = 1'b0;
        #1;
        check("midrst_rd_en", if0.rd_en, 0);
        check("midrst_busy", if0.busy, 0);
        check("midrst_dout_valid", if0.dout_valid, 0);
        check("midrst_din_ready", if0.din_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        send_sample(16'h7FFF, y);
        check("midrst_impulse_0", y, 16'h4000);
        send_sample(16'h0000, y);
        check("midrst_impulse_1", y, 16'h4000);
        check("midrst_sync_err", if0.coef_sync_err, 0);

        // Sync fault: coef_done forced high on c[10].
        do_reset();
        fault_tap = 10;
        send_sample(16'h0100, y);
        check("sync_err_set", if0.coef_sync_err, 1);
        fault_tap = -1;
        send_sample(16'h0100, y);
        check("sync_err_sticky", if0.coef_sync_err, 1);
        do_reset();
        @(negedge clk);
        check("sync_err_cleared", if0.coef_sync_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
